// File: rtl/mxint_vector_cast_pkg.sv
// Shared helpers for MXINT re-quantisation: shift-count width and exponent clamp bounds.
package mxint_cast_pkg;

  // Shift never exceeds MAN_WIDTH-1, so $clog2(MAN_WIDTH) bits hold it.
  function automatic int shift_w(int man_w);
    return (man_w > 1) ? $clog2(man_w) : 1;
  endfunction

  function automatic int width_w(int man_w);
    return $clog2(man_w + 1);
  endfunction

  function automatic int exp_max(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int exp_min(int exp_w);
    return -(1 << (exp_w - 1));
  endfunction

endpackage

// File: rtl/mxint_vector_cast_if.sv
// MXINT block stream: BLOCK_SIZE mantissas sharing one exponent, valid/ready handshake.
interface mxint_vector_cast_if #(
  parameter int MAN_WIDTH  = 15,
  parameter int EXP_WIDTH  = 9,
  parameter int BLOCK_SIZE = 6
);
  logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0] mdata;
  logic [EXP_WIDTH-1:0]                 edata;
  logic                                 valid;
  logic                                 ready;

  modport master (output mdata, edata, valid, input  ready);
  modport slave  (input  mdata, edata, valid, output ready);
endinterface

// File: rtl/mxint_vector_cast_width.sv
// Minimum signed width of each mantissa, reduced to the block maximum.
module mxint_block_width
  import mxint_cast_pkg::*;
#(
  parameter int MAN_WIDTH  = 15,
  parameter int BLOCK_SIZE = 6
) (
  input  logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0]   man,
  output logic [width_w(MAN_WIDTH)-1:0]          width
);
  localparam int WW = width_w(MAN_WIDTH);

  logic [BLOCK_SIZE-1:0][WW-1:0] lane_w;

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    logic [WW-1:0] sw;
    // Highest bit differing from the sign bit sets the width (+1 for sign).
    always_comb begin
      sw = WW'(1);
      for (int k = 0; k < MAN_WIDTH - 1; k++)
        if (man[i][k] != man[i][MAN_WIDTH-1]) sw = WW'(k + 2);
    end
    assign lane_w[i] = sw;
  end

  always_comb begin
    width = lane_w[0];
    for (int i = 1; i < BLOCK_SIZE; i++)
      if (lane_w[i] > width) width = lane_w[i];
  end
endmodule

// File: rtl/mxint_vector_cast.sv
// Two-stage MXINT narrowing cast with valid/ready backpressure.
// MXINT_CAST_ROUND_EN selects round-half-up with saturation instead of truncation.
module mxint_vector_cast
  import mxint_cast_pkg::*;
#(
  parameter int IN_MAN_WIDTH  = 15,
  parameter int IN_EXP_WIDTH  = 9,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 6
) (
  input logic                 clk,
  input logic                 rst,
  mxint_vector_cast_if.slave  data_in,
  mxint_vector_cast_if.master data_out
);
  localparam int SW      = shift_w(IN_MAN_WIDTH);
  localparam int WW      = width_w(IN_MAN_WIDTH);
  localparam int EXP_MAX = exp_max(OUT_EXP_WIDTH);
  localparam int EXP_MIN = exp_min(OUT_EXP_WIDTH);

  // Stage-1 payload; widths follow this instance's parameters.
  typedef struct packed {
    logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0] man;
    logic [IN_EXP_WIDTH-1:0]                 exp;
    logic [SW-1:0]                           shift;
  } s1_payload_t;

  logic [2:1]                               vld_pipe;
  s1_payload_t                              s1_q, s1_nxt;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] man_q, man_nxt;
  logic [OUT_EXP_WIDTH-1:0]                 exp_q, exp_nxt;
  logic [WW-1:0]                            blk_w;
  logic signed [IN_EXP_WIDTH:0]             e_sum;
  logic                                     s2_ready, in_ready;

  assign s2_ready      = !vld_pipe[2] || data_out.ready;
  assign in_ready      = !vld_pipe[1] || s2_ready;
  assign data_in.ready = in_ready;

  mxint_block_width #(.MAN_WIDTH(IN_MAN_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_width (
    .man   (data_in.mdata),
    .width (blk_w)
  );

  always_comb begin
    s1_nxt.man   = data_in.mdata;
    s1_nxt.exp   = data_in.edata;
    s1_nxt.shift = (blk_w > WW'(OUT_MAN_WIDTH)) ? SW'(blk_w - WW'(OUT_MAN_WIDTH)) : '0;
  end

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    logic signed [IN_MAN_WIDTH-1:0] m;
    assign m = s1_q.man[i];
`ifdef MXINT_CAST_ROUND_EN
    localparam logic signed [IN_MAN_WIDTH:0] MAN_MAX = (IN_MAN_WIDTH+1)'((1 << (OUT_MAN_WIDTH - 1)) - 1);
    logic        [IN_MAN_WIDTH:0] bias;
    logic signed [IN_MAN_WIDTH:0] sum, rnd;
    // Extra bit keeps the half-LSB bias from wrapping the largest positive mantissa.
    assign bias       = (s1_q.shift == '0) ? '0 : (IN_MAN_WIDTH+1)'(1) << (s1_q.shift - SW'(1));
    assign sum        = $signed({m[IN_MAN_WIDTH-1], m}) + $signed(bias);
    assign rnd        = sum >>> s1_q.shift;
    assign man_nxt[i] = (rnd > MAN_MAX) ? OUT_MAN_WIDTH'(MAN_MAX) : OUT_MAN_WIDTH'(rnd);
`else
    assign man_nxt[i] = OUT_MAN_WIDTH'(m >>> s1_q.shift);
`endif
  end

  assign e_sum   = $signed({s1_q.exp[IN_EXP_WIDTH-1], s1_q.exp}) + $signed((IN_EXP_WIDTH+1)'(s1_q.shift));
  assign exp_nxt = (e_sum > EXP_MAX) ? OUT_EXP_WIDTH'(EXP_MAX) :
                   (e_sum < EXP_MIN) ? OUT_EXP_WIDTH'(EXP_MIN) : OUT_EXP_WIDTH'(e_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      man_q    <= '0;
      exp_q    <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= data_in.valid;
        if (data_in.valid) s1_q <= s1_nxt;
      end
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          man_q <= man_nxt;
          exp_q <= exp_nxt;
        end
      end
    end
  end

  assign data_out.mdata = man_q;
  assign data_out.edata = exp_q;
  assign data_out.valid = vld_pipe[2];
endmodule

// File: tb/tb_mxint_vector_cast.sv
// Directed and random-backpressure bench for mxint_vector_cast (default 15/9 -> 8/8, 6 lanes).
module tb_mxint_vector_cast;
  typedef logic [5:0][14:0] min_t;
  typedef logic [5:0][7:0]  mout_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mxint_vector_cast_if #(.MAN_WIDTH(15), .EXP_WIDTH(9), .BLOCK_SIZE(6)) din ();
  mxint_vector_cast_if #(.MAN_WIDTH(8),  .EXP_WIDTH(8), .BLOCK_SIZE(6)) dout ();

  mxint_vector_cast dut (.clk(clk), .rst(rst), .data_in(din), .data_out(dout));

  function automatic min_t mk(int a, int b, int c, int d, int e, int f);
    min_t r;
    r[0] = 15'(a); r[1] = 15'(b); r[2] = 15'(c);
    r[3] = 15'(d); r[4] = 15'(e); r[5] = 15'(f);
    return r;
  endfunction

  function automatic mout_t mko(int a, int b, int c, int d, int e, int f);
    mout_t r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c);
    r[3] = 8'(d); r[4] = 8'(e); r[5] = 8'(f);
    return r;
  endfunction

  // Reference model for random traffic: width by range test, integer shift.
  function automatic void model(input min_t m, input int e, output mout_t mo, output logic [7:0] eo);
    int w, s, v, r, ex;
    w = 1;
    for (int i = 0; i < 6; i++) begin
      v = int'($signed(m[i]));
      for (int k = 1; k <= 15; k++)
        if (v >= -(1 << (k - 1)) && v < (1 << (k - 1))) begin
          if (k > w) w = k;
          break;
        end
    end
    s = (w > 8) ? w - 8 : 0;
    for (int i = 0; i < 6; i++) begin
      v = int'($signed(m[i]));
`ifdef MXINT_CAST_ROUND_EN
      r = (s > 0) ? ((v + (1 << (s - 1))) >>> s) : v;
      if (r > 127) r = 127;
`else
      r = v >>> s;
`endif
      mo[i] = 8'(r);
    end
    ex = e + s;
    if (ex > 127) ex = 127;
    if (ex < -128) ex = -128;
    eo = 8'(ex);
  endfunction

  function automatic min_t rand_blk();
    min_t r;
    for (int i = 0; i < 6; i++)
      r[i] = 15'(int'($signed(15'($urandom))) >>> $urandom_range(0, 14));
    return r;
  endfunction

  // Sends one block into an empty pipe and captures the first output; lat=-1 on timeout.
  task automatic xfer(input min_t m, input int e, output mout_t mo, output logic [7:0] eo, output int lat);
    int n;
    din.mdata = m; din.edata = 9'(e); din.valid = 1'b1; dout.ready = 1'b1;
    lat = -1; mo = '0; eo = '0; n = 0;
    @(negedge clk);
    while (!din.ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    din.valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dout.valid) begin lat = k; mo = dout.mdata; eo = dout.edata; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din.valid = 1'b0; dout.ready = 1'b1; din.mdata = '0; din.edata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (dout.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dout.valid); end
    checks++; if (dout.mdata !== '0) begin failures++; $display("FAIL reset_mdata got=%h exp=0", dout.mdata); end
    checks++; if (dout.edata !== 8'h00) begin failures++; $display("FAIL reset_edata got=%h exp=00", dout.edata); end
    checks++; if (din.ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", din.ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    mout_t mo, em; logic [7:0] eo; int lat;
`ifdef MXINT_CAST_ROUND_EN
    em = mko(125, 0, 0, 0, 0, 0);
`else
    em = mko(125, -1, 0, 0, 0, 0);
`endif
    xfer(mk(1000, -3, 0, 0, 0, 0), 2, mo, eo, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (mo !== em) begin failures++; $display("FAIL basic_mdata got=%h exp=%h", mo, em); end
    checks++; if (eo !== 8'd5) begin failures++; $display("FAIL basic_edata got=%h exp=05", eo); end
  endtask

  task automatic test_no_shift();
    mout_t mo; logic [7:0] eo; int lat;
    xfer(mk(127, -128, 5, 0, 0, 0), -7, mo, eo, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL noshift_latency got=%0d exp=2", lat); end
    checks++; if (mo !== mko(127, -128, 5, 0, 0, 0)) begin failures++; $display("FAIL noshift_mdata got=%h exp=%h", mo, mko(127, -128, 5, 0, 0, 0)); end
    checks++; if (eo !== 8'hf9) begin failures++; $display("FAIL noshift_edata got=%h exp=f9", eo); end
    xfer(mk(128, 0, 0, 0, 0, 0), 0, mo, eo, lat);
    checks++; if (mo !== mko(64, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL shift1_mdata got=%h exp=%h", mo, mko(64, 0, 0, 0, 0, 0)); end
    checks++; if (eo !== 8'd1) begin failures++; $display("FAIL shift1_edata got=%h exp=01", eo); end
  endtask

  task automatic test_saturate();
    mout_t mo; logic [7:0] eo; int lat;
    // 1023>>3 is 127 truncated; rounded (1027>>3=128) it saturates to 127.
    xfer(mk(1023, 0, 0, 0, 0, 0), 0, mo, eo, lat);
    checks++; if (mo !== mko(127, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL sat_mdata got=%h exp=%h", mo, mko(127, 0, 0, 0, 0, 0)); end
    checks++; if (eo !== 8'd3) begin failures++; $display("FAIL sat_edata got=%h exp=03", eo); end
  endtask

  task automatic test_exp_clamp();
    mout_t mo; logic [7:0] eo; int lat;
    xfer(mk(1000, 0, 0, 0, 0, 0), 126, mo, eo, lat);
    checks++; if (eo !== 8'h7f) begin failures++; $display("FAIL clamp_hi_edata got=%h exp=7f", eo); end
    checks++; if (mo !== mko(125, 0, 0, 0, 0, 0)) begin failures++; $display("FAIL clamp_hi_mdata got=%h exp=%h", mo, mko(125, 0, 0, 0, 0, 0)); end
    xfer(mk(0, 0, 0, 0, 0, 0), -200, mo, eo, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL clamp_lo_latency got=%0d exp=2", lat); end
    checks++; if (eo !== 8'h80) begin failures++; $display("FAIL clamp_lo_edata got=%h exp=80", eo); end
    checks++; if (mo !== '0) begin failures++; $display("FAIL clamp_lo_mdata got=%h exp=0", mo); end
  endtask

  task automatic test_stream();
    min_t blk[8]; int eb[8]; mout_t em[8]; logic [7:0] ee[8];
    int got = 0, first = 0, last = 0;
    for (int i = 0; i < 8; i++) begin
      blk[i] = rand_blk(); eb[i] = int'($urandom_range(0, 511)) - 256;
      model(blk[i], eb[i], em[i], ee[i]);
    end
    dout.ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          din.mdata = blk[i]; din.edata = 9'(eb[i]); din.valid = 1'b1;
          @(negedge clk);
          checks++; if (din.ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready blk=%0d got=%b exp=1", i, din.ready); end
          @(posedge clk); #1;
        end
        din.valid = 1'b0;
      end
      begin
        for (int n = 0; n < 40 && got < 8; n++) begin
          @(negedge clk);
          if (dout.valid) begin
            checks++;
            if (dout.mdata !== em[got] || dout.edata !== ee[got]) begin
              failures++; $display("FAIL stream_data blk=%0d got=%h/%h exp=%h/%h", got, dout.mdata, dout.edata, em[got], ee[got]);
            end
            if (got == 0) first = cyc;
            last = cyc; got++;
          end
        end
      end
    join
    checks++; if (got !== 8 || last - first !== 7) begin failures++; $display("FAIL stream_rate got=%0d blocks over %0d cycles exp=8 over 7", got, last - first); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    mout_t em[$]; logic [7:0] ee[$]; min_t blk[20]; int eb[20];
    mout_t tm; logic [7:0] te; int got = 0; logic extra;
    for (int i = 0; i < 20; i++) begin
      blk[i] = rand_blk(); eb[i] = int'($urandom_range(0, 511)) - 256;
      model(blk[i], eb[i], tm, te); em.push_back(tm); ee.push_back(te);
    end
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int n;
          din.mdata = blk[i]; din.edata = 9'(eb[i]); din.valid = 1'b1; n = 0;
          @(negedge clk);
          while (!din.ready && n < 200) begin @(negedge clk); n++; end
          @(posedge clk); #1;
        end
        din.valid = 1'b0;
      end
      begin
        for (int n = 0; n < 2000 && got < 20; n++) begin
          dout.ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        dout.ready = 1'b1;
      end
      begin
        logic held; mout_t hm; logic [7:0] he;
        held = 1'b0; hm = '0; he = '0;
        for (int n = 0; n < 2000 && got < 20; n++) begin
          @(negedge clk);
          if (held) begin
            checks++;
            if (dout.valid !== 1'b1 || dout.mdata !== hm || dout.edata !== he) begin
              failures++; $display("FAIL b2b_stable got=%b/%h/%h exp=1/%h/%h", dout.valid, dout.mdata, dout.edata, hm, he);
            end
          end
          held = 1'b0;
          if (dout.valid) begin
            if (dout.ready) begin
              checks++;
              if (em.size() == 0) begin
                failures++; $display("FAIL b2b_dup got=%h exp=none", dout.mdata);
              end else begin
                tm = em.pop_front(); te = ee.pop_front();
                if (dout.mdata !== tm || dout.edata !== te) begin
                  failures++; $display("FAIL b2b_data blk=%0d got=%h/%h exp=%h/%h", got, dout.mdata, dout.edata, tm, te);
                end
              end
              got++;
            end else begin
              held = 1'b1; hm = dout.mdata; he = dout.edata;
            end
          end
        end
      end
    join
    checks++; if (got !== 20) begin failures++; $display("FAIL b2b_count got=%0d exp=20", got); end
    extra = 1'b0;
    repeat (4) begin @(negedge clk); if (dout.valid) extra = 1'b1; end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL b2b_extra got=%b exp=0", extra); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    dout.ready = 1'b0;
    din.mdata = mk(1000, 1, 2, 3, 4, 5); din.edata = 9'd10; din.valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 din.valid = 1'b0;
    @(negedge clk);
    checks++; if (din.ready !== 1'b0 || dout.valid !== 1'b1) begin failures++; $display("FAIL full_pipe got=ready %b valid %b exp=ready 0 valid 1", din.ready, dout.valid); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (dout.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", dout.valid); end
    checks++; if (din.ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", din.ready); end
    dout.ready = 1'b1; seen = 1'b0;
    repeat (5) begin @(negedge clk); if (dout.valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_leak got=%b exp=0", seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    din.valid = 1'b0; din.mdata = '0; din.edata = '0; dout.ready = 1'b1;
    test_reset();
    test_basic();
    test_no_shift();
    test_saturate();
    test_exp_clamp();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
